// File: rtl/victim_iter.sv
// Priority-board sequencer: drives a working board into the external square arbiter and
// emits candidates highest-priority first. Optional abort port: define VICTIM_ITER_ABORT_EN.
module victim_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [191:0] priority_in,
    output logic [191:0] arb_priority,
    input  logic [6:0]   arb_data,
`ifdef VICTIM_ITER_ABORT_EN
    input  logic         abort,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [5:0]   out_sq,
    output logic [2:0]   out_pri,
    output logic         busy,
    output logic         done,
    output logic [6:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVAL  = 2'd1,
        S_OFFER = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [191:0]   pri_q, pri_d;
    logic [5:0]     sq_q, sq_d;
    logic [2:0]     pq_q, pq_d;
    logic [6:0]     count_q, count_d;
    logic           abort_w;

`ifdef VICTIM_ITER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pri_q   <= '0;
            sq_q    <= '0;
            pq_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            sq_q    <= sq_d;
            pq_q    <= pq_d;
            count_q <= count_d;
        end
    end

    // Abort outranks both the arbiter result and the handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_EVAL;
            S_EVAL: begin
                if (abort_w)          state_d = S_IDLE;
                else if (arb_data[6]) state_d = S_DONE;
                else                  state_d = S_OFFER;
            end
            S_OFFER: begin
                if (abort_w)        state_d = S_IDLE;
                else if (out_ready) state_d = S_EVAL;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pri_d   = pri_q;
        sq_d    = sq_q;
        pq_d    = pq_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pri_d   = priority_in;
                    count_d = '0;
                end
            end
            S_EVAL: begin
                if (!abort_w && !arb_data[6]) begin
                    sq_d = arb_data[5:0];
                    pq_d = pri_q[3*arb_data[5:0] +: 3];
                end
            end
            S_OFFER: begin
                // Clearing the accepted square lets the arbiter surface the next one.
                if (out_ready && !abort_w) begin
                    pri_d[3*sq_q +: 3] = 3'd0;
                    count_d            = count_q + 7'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            S_IDLE:  busy      = 1'b0;
            S_OFFER: out_valid = 1'b1;
            S_DONE:  done      = 1'b1;
            default: ;
        endcase
    end

    assign arb_priority = pri_q;
    assign out_sq       = sq_q;
    assign out_pri      = pq_q;
    assign count        = count_q;

endmodule

// File: tb/tb_victim_iter.sv
// Directed bench for victim_iter with a behavioural square arbiter closing the loop.
module tb_victim_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [191:0] priority_in;
    logic [191:0] arb_priority;
    logic [6:0]   arb_data;
    logic         out_valid;
    logic         out_ready;
    logic [5:0]   out_sq;
    logic [2:0]   out_pri;
    logic         busy;
    logic         done;
    logic [6:0]   count;
`ifdef VICTIM_ITER_ABORT_EN
    logic         abort;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    victim_iter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .priority_in  (priority_in),
        .arb_priority (arb_priority),
        .arb_data     (arb_data),
`ifdef VICTIM_ITER_ABORT_EN
        .abort        (abort),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sq       (out_sq),
        .out_pri      (out_pri),
        .busy         (busy),
        .done         (done),
        .count        (count)
    );

    // Arbiter: max priority, lowest index on ties, bit 6 flags an empty board.
    always_comb begin
        logic [2:0] best_p;
        logic [5:0] best_s;
        best_p = 3'd0;
        best_s = 6'd0;
        for (int s = 0; s < 64; s++) begin
            if (arb_priority[3*s +: 3] > best_p) begin
                best_p = arb_priority[3*s +: 3];
                best_s = 6'(s);
            end
        end
        arb_data = {(best_p == 3'd0), best_s};
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Leaves the bench in cycle t+1 where t is the edge that samples start.
    task automatic launch(input logic [191:0] board);
        priority_in = board;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        n_tests++;
        if ({out_valid, busy, done} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000", {out_valid, busy, done});
        end
        n_tests++;
        if ({out_sq, out_pri, count} !== 16'd0 || arb_priority !== 192'd0) begin
            n_fail++; $display("FAIL reset_data: sq=%0d pri=%0d cnt=%0d arb=%h want zeros", out_sq, out_pri, count, arb_priority);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ordering();
        logic [191:0] b;
        b = '0;
        b[3*10 +: 3] = 3'd2;
        b[3*3  +: 3] = 3'd5;
        b[3*40 +: 3] = 3'd7;
        out_ready = 1'b1;
        launch(b);
        priority_in = {192{1'b1}};
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL ord_eval: valid=%b busy=%b want 0 1", out_valid, busy);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b1 || out_sq !== 6'd40 || out_pri !== 3'd7) begin
            n_fail++; $display("FAIL ord_first: valid=%b sq=%0d pri=%0d want 1 40 7", out_valid, out_sq, out_pri);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL ord_gap: valid=%b want 0", out_valid);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b1 || out_sq !== 6'd3 || out_pri !== 3'd5) begin
            n_fail++; $display("FAIL ord_second: valid=%b sq=%0d pri=%0d want 1 3 5", out_valid, out_sq, out_pri);
        end
        step(); step();
        n_tests++;
        if (out_valid !== 1'b1 || out_sq !== 6'd10 || out_pri !== 3'd2) begin
            n_fail++; $display("FAIL ord_third: valid=%b sq=%0d pri=%0d want 1 10 2", out_valid, out_sq, out_pri);
        end
        step();
        n_tests++;
        if (count !== 7'd3 || done !== 1'b0) begin
            n_fail++; $display("FAIL ord_count: count=%0d done=%b want 3 0", count, done);
        end
        step();
        n_tests++;
        if (done !== 1'b1 || count !== 7'd3 || arb_priority !== 192'd0) begin
            n_fail++; $display("FAIL ord_done: done=%b count=%0d arb=%h want 1 3 0", done, count, arb_priority);
        end
        n_tests++;
        if (out_sq !== 6'd10 || out_pri !== 3'd2) begin
            n_fail++; $display("FAIL ord_hold: sq=%0d pri=%0d want 10 2", out_sq, out_pri);
        end
        step();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL ord_idle: busy=%b done=%b want 0 0", busy, done);
        end
        priority_in = '0;
    endtask

    task automatic test_empty();
        out_ready = 1'b1;
        launch(192'd0);
        n_tests++;
        if (busy !== 1'b1 || count !== 7'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL empty_eval: busy=%b count=%0d valid=%b want 1 0 0", busy, count, out_valid);
        end
        step();
        n_tests++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL empty_done: done=%b valid=%b want 1 0", done, out_valid);
        end
        step();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || count !== 7'd0) begin
            n_fail++; $display("FAIL empty_idle: busy=%b done=%b count=%0d want 0 0 0", busy, done, count);
        end
    endtask

    task automatic test_tie();
        logic [191:0] b;
        logic [5:0]   exp_sq [3];
        b = '0;
        b[3*63 +: 3] = 3'd4;
        b[3*17 +: 3] = 3'd4;
        b[3*9  +: 3] = 3'd4;
        exp_sq = '{6'd9, 6'd17, 6'd63};
        out_ready = 1'b1;
        launch(b);
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_sq !== exp_sq[k] || out_pri !== 3'd4) begin
                n_fail++; $display("FAIL tie_%0d: valid=%b sq=%0d pri=%0d want 1 %0d 4", k, out_valid, out_sq, out_pri, exp_sq[k]);
            end
            step();
        end
        step();
        n_tests++;
        if (done !== 1'b1 || count !== 7'd3) begin
            n_fail++; $display("FAIL tie_done: done=%b count=%0d want 1 3", done, count);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [191:0] b;
        b = '0;
        b[3*5 +: 3] = 3'd1;
        out_ready = 1'b0;
        launch(b);
        for (int k = 0; k < 5; k++) begin
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_sq !== 6'd5 || out_pri !== 3'd1) begin
                n_fail++; $display("FAIL bp_hold_%0d: valid=%b sq=%0d pri=%0d want 1 5 1", k, out_valid, out_sq, out_pri);
            end
        end
        out_ready = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || count !== 7'd1) begin
            n_fail++; $display("FAIL bp_eval: valid=%b busy=%b done=%b count=%0d want 0 1 0 1", out_valid, busy, done, count);
        end
        step();
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL bp_done: done=%b want 1", done);
        end
        step();
    endtask

    task automatic test_full();
        out_ready = 1'b1;
        launch({64{3'b001}});
        for (int k = 0; k < 64; k++) begin
            start = (k < 60);
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_sq !== 6'(k) || out_pri !== 3'd1) begin
                n_fail++; $display("FAIL full_sq_%0d: valid=%b sq=%0d pri=%0d want 1 %0d 1", k, out_valid, out_sq, out_pri, k);
            end
            step();
        end
        start = 1'b0;
        n_tests++;
        if (count !== 7'd64 || done !== 1'b0) begin
            n_fail++; $display("FAIL full_count: count=%0d done=%b want 64 0", count, done);
        end
        step();
        n_tests++;
        if (done !== 1'b1 || count !== 7'd64) begin
            n_fail++; $display("FAIL full_done: done=%b count=%0d want 1 64", done, count);
        end
        start = 1'b1;
        step();
        n_tests++;
        if (busy !== 1'b0 || count !== 7'd64) begin
            n_fail++; $display("FAIL start_in_done: busy=%b count=%0d want 0 64", busy, count);
        end
        step();
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || count !== 7'd0) begin
            n_fail++; $display("FAIL start_after_done: busy=%b count=%0d want 1 0", busy, count);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        logic [191:0] b;
        int           seen_done;
        b = '0;
        b[3*5 +: 3] = 3'd3;
        out_ready = 1'b0;
        launch(b);
        step();
        n_tests++;
        if (out_valid !== 1'b1 || out_sq !== 6'd5 || out_pri !== 3'd3) begin
            n_fail++; $display("FAIL rst_pre: valid=%b sq=%0d pri=%0d want 1 5 3", out_valid, out_sq, out_pri);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, busy, done} !== 3'b000 || {out_sq, out_pri, count} !== 16'd0 || arb_priority !== 192'd0) begin
            n_fail++; $display("FAIL rst_async: valid=%b busy=%b done=%b sq=%0d pri=%0d cnt=%0d want all 0", out_valid, busy, done, out_sq, out_pri, count);
        end
        out_ready = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (done !== 1'b0) seen_done++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
        end
        n_tests++;
        if (seen_done != 0) begin
            n_fail++; $display("FAIL rst_no_done: %0d cycles with done/busy set, want 0", seen_done);
        end
    endtask

`ifdef VICTIM_ITER_ABORT_EN
    task automatic test_abort();
        logic [191:0] b;
        logic [191:0] exp_b;
        b = '0;
        b[3*2 +: 3] = 3'd6;
        b[3*7 +: 3] = 3'd3;
        exp_b = '0;
        exp_b[3*7 +: 3] = 3'd3;
        out_ready = 1'b1;
        launch(b);
        step(); step(); step();
        n_tests++;
        if (out_valid !== 1'b1 || out_sq !== 6'd7 || count !== 7'd1) begin
            n_fail++; $display("FAIL abort_pre: valid=%b sq=%0d count=%0d want 1 7 1", out_valid, out_sq, count);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || count !== 7'd1 || arb_priority !== exp_b) begin
            n_fail++; $display("FAIL abort_idle: busy=%b valid=%b done=%b count=%0d arb=%h want 0 0 0 1 %h", busy, out_valid, done, count, arb_priority, exp_b);
        end
        step();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_done: done=%b busy=%b want 0 0", done, busy);
        end
    endtask
`endif

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        priority_in = '0;
        out_ready   = 1'b0;
`ifdef VICTIM_ITER_ABORT_EN
        abort       = 1'b0;
`endif
        test_reset();
        test_ordering();
        test_empty();
        test_tie();
        test_backpressure();
        test_full();
        test_reset_mid();
`ifdef VICTIM_ITER_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
